// File: rtl/enc_pkg.sv
// Shared definitions for the prio_encoder_hs block: arbitration mode encodings.
package enc_pkg;

  // Arbitration mode: fixed highest-index priority or round-robin.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : enc_pkg

// File: rtl/prio_pick.sv
// Combinational request picker: fixed highest-index or round-robin search,
// plus a "more than one request" flag. No state lives here.
module prio_pick
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic                 mode,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found,
  output logic                 multi
);

  localparam int W = $clog2(N);

  logic [2*N-1:0] req_dbl_s;
  logic [N-1:0]   req_rot_s;
  logic [W-1:0]   fix_idx_s;
  logic [W-1:0]   rr_off_s;
  logic [W:0]     rr_sum_s;
  logic [W:0]     rr_wrap_s;
  logic [W-1:0]   rr_idx_s;

  // Rotate the request vector so that bit 0 of req_rot_s is request 'start'.
  always_comb begin
    req_dbl_s = {req, req};
    req_rot_s = req_dbl_s[start +: N];
  end

  // Fixed priority: ascending scan, the last set bit seen is the highest index.
  always_comb begin
    fix_idx_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        fix_idx_s = W'(k);
      end else begin
        fix_idx_s = fix_idx_s;
      end
    end
  end

  // Round-robin: descending scan of the rotated vector keeps the lowest offset.
  always_comb begin
    rr_off_s = {W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot_s[k]) begin
        rr_off_s = W'(k);
      end else begin
        rr_off_s = rr_off_s;
      end
    end
  end

  // Convert the rotated offset back to an absolute index, modulo N.
  always_comb begin
    rr_sum_s  = {1'b0, start} + {1'b0, rr_off_s};
    rr_wrap_s = rr_sum_s - (W + 1)'(N);
    if (rr_sum_s >= (W + 1)'(N)) begin
      rr_idx_s = rr_wrap_s[W-1:0];
    end else begin
      rr_idx_s = rr_sum_s[W-1:0];
    end
  end

  // Select the result of the active mode and derive found/multi flags.
  always_comb begin
    found = |req;
    multi = |(req & (req - N'(1)));
    case (mode)
      MODE_FIXED: idx = fix_idx_s;
      MODE_RR:    idx = rr_idx_s;
      default:    idx = fix_idx_s;
    endcase
  end

endmodule : prio_pick

// File: rtl/prio_encoder_hs.sv
// Registered N-to-log2(N) priority encoder with fixed / round-robin arbitration
// and a valid/ready output handshake. The outputs come straight from flops;
// out_ready only gates the load enable.
module prio_encoder_hs
  import enc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 mode,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_multi
);

  localparam int W = $clog2(N);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q,   idx_d;
  logic         multi_q, multi_d;
  logic [W-1:0] ptr_q,   ptr_d;

  logic         load_s;
  logic [W-1:0] start_s;
  logic [W-1:0] pick_idx_s;
  logic         pick_found_s;
  logic         pick_multi_s;

  // Round-robin search begins one past the last grant, wrapping N-1 -> 0.
  always_comb begin
    if (ptr_q == W'(N - 1)) begin
      start_s = {W{1'b0}};
    end else begin
      start_s = ptr_q + W'(1);
    end
  end

  prio_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .start (start_s),
    .mode  (mode),
    .idx   (pick_idx_s),
    .found (pick_found_s),
    .multi (pick_multi_s)
  );

  // Next-state: load when the output slot is empty or being consumed.
  always_comb begin
    load_s  = !valid_q || out_ready;
    valid_d = valid_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    ptr_d   = ptr_q;
    if (load_s) begin
      if (pick_found_s) begin
        valid_d = 1'b1;
        idx_d   = pick_idx_s;
        multi_d = pick_multi_s;
        ptr_d   = pick_idx_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output and pointer registers; reset wins over any load or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= {W{1'b0}};
      multi_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_multi = multi_q;

endmodule : prio_encoder_hs

// File: tb/tb_prio_encoder_hs.sv
// Self-checking bench for prio_encoder_hs at N=8, N=4 and N=16.
// A behavioural arbiter model tracks each instance and is compared every cycle;
// directed steps also pin hand-computed values on the N=8 and N=16 instances.
module tb_prio_encoder_hs;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        out_ready;
  logic [7:0]  req8;
  logic [3:0]  req4;
  logic [15:0] req16;

  logic        valid8, multi8;
  logic [2:0]  idx8;
  logic        valid4, multi4;
  logic [1:0]  idx4;
  logic        valid16, multi16;
  logic [3:0]  idx16;

  int errors = 0;
  int checks = 0;

  prio_encoder_hs #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .mode(mode), .out_ready(out_ready),
    .out_valid(valid8), .out_idx(idx8), .out_multi(multi8)
  );

  prio_encoder_hs #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .mode(mode), .out_ready(out_ready),
    .out_valid(valid4), .out_idx(idx4), .out_multi(multi4)
  );

  prio_encoder_hs #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .req(req16), .mode(mode), .out_ready(out_ready),
    .out_valid(valid16), .out_idx(idx16), .out_multi(multi16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Arbitration rule: fixed = highest set index; round-robin = first set
  // index found walking upward from ptr+1 around the ring. -1 if none.
  function automatic int arb(input int n, input logic [63:0] r, input logic m, input int p);
    if (m == 1'b0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int d = 1; d <= n; d++) if (r[(p + d) % n]) return (p + d) % n;
    end
    return -1;
  endfunction

  // Model state, one slot per instance: 0 -> N=8, 1 -> N=4, 2 -> N=16.
  int   m_n[3] = '{8, 4, 16};
  bit   m_valid[3];
  int   m_idx[3];
  bit   m_multi[3];
  int   m_ptr[3];
  bit   m_ok = 1'b0;

  // Model update on each rising edge using the inputs held across that edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [63:0] rv;
      int s;
      rv = (k == 0) ? 64'(req8) : ((k == 1) ? 64'(req4) : 64'(req16));
      s  = arb(m_n[k], rv, mode, m_ptr[k]);
      if (rst) begin
        m_valid[k] <= 1'b0;
        m_idx[k]   <= 0;
        m_multi[k] <= 1'b0;
        m_ptr[k]   <= m_n[k] - 1;
      end else if (!m_valid[k] || out_ready) begin
        if (s >= 0) begin
          m_valid[k] <= 1'b1;
          m_idx[k]   <= s;
          m_multi[k] <= ($countones(rv) > 1);
          m_ptr[k]   <= s;
        end else begin
          m_valid[k] <= 1'b0;
        end
      end
    end
    if (rst) m_ok <= 1'b1;
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("n8.valid",  int'(valid8),  int'(m_valid[0]));
      chk("n8.idx",    int'(idx8),    m_idx[0]);
      chk("n8.multi",  int'(multi8),  int'(m_multi[0]));
      chk("n4.valid",  int'(valid4),  int'(m_valid[1]));
      chk("n4.idx",    int'(idx4),    m_idx[1]);
      chk("n4.multi",  int'(multi4),  int'(m_multi[1]));
      chk("n16.valid", int'(valid16), int'(m_valid[2]));
      chk("n16.idx",   int'(idx16),   m_idx[2]);
      chk("n16.multi", int'(multi16), int'(m_multi[2]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] r);
    req8  = r;
    req4  = r[3:0];
    req16 = {r, r};
  endtask

  initial begin
    int rr_exp[5];
    rr_exp = '{0, 2, 5, 0, 2};
    rst = 1'b1; mode = 1'b1; out_ready = 1'b1;
    set_req(8'hFF);
    tick(); tick();
    chk("lit.reset.valid", int'(valid8), 0);
    chk("lit.reset.idx",   int'(idx8),   0);
    chk("lit.reset.multi", int'(multi8), 0);

    // First round-robin grant after reset starts at index 0.
    rst = 1'b0;
    tick();
    chk("lit.rr_first.idx",   int'(idx8),   0);
    chk("lit.rr_first.multi", int'(multi8), 1);

    // One-hot sweep in fixed mode across all three widths.
    mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req16 = 16'(1) << i;
      req8  = 8'(1) << (i % 8);
      req4  = 4'(1) << (i % 4);
      tick();
      chk("lit.sweep8.idx",   int'(idx8),   i % 8);
      chk("lit.sweep8.valid", int'(valid8), 1);
      chk("lit.sweep8.multi", int'(multi8), 0);
      chk("lit.sweep16.idx",  int'(idx16),  i);
      chk("lit.sweep4.idx",   int'(idx4),   i % 4);
    end

    // Fixed priority with several requests.
    set_req(8'b1010_0100);
    tick();
    chk("lit.fixed.idx",   int'(idx8),   7);
    chk("lit.fixed.multi", int'(multi8), 1);

    // Round-robin rotation over bits 0, 2, 5.
    mode = 1'b1;
    set_req(8'b0010_0101);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("lit.rr.idx",   int'(idx8),   rr_exp[i]);
      chk("lit.rr.multi", int'(multi8), 1);
    end

    // Back-pressure: outputs hold and req is ignored while stalled.
    mode = 1'b0;
    set_req(8'h08);
    tick();
    chk("lit.bp_load.idx", int'(idx8), 3);
    out_ready = 1'b0;
    set_req(8'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit.bp_hold.idx",   int'(idx8),   3);
      chk("lit.bp_hold.valid", int'(valid8), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("lit.bp_release.idx", int'(idx8), 6);

    // Stall again, then reset in the middle of it.
    out_ready = 1'b0;
    set_req(8'h02);
    tick(); tick();
    chk("lit.stall2.idx", int'(idx8), 6);
    rst = 1'b1;
    tick();
    chk("lit.rst_stall.valid", int'(valid8), 0);
    chk("lit.rst_stall.idx",   int'(idx8),   0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Idle: valid drops, index holds.
    set_req(8'h08);
    tick();
    set_req(8'h00);
    tick();
    chk("lit.idle.valid", int'(valid8), 0);
    chk("lit.idle.idx",   int'(idx8),   3);

    // Single request at ptr's own index is re-granted after a full wrap.
    mode = 1'b1;
    set_req(8'h08);
    tick();
    chk("lit.wrap.idx", int'(idx8), 3);
    tick();
    chk("lit.wrap2.idx",   int'(idx8),   3);
    chk("lit.wrap2.valid", int'(valid8), 1);

    // Mixed random traffic, checked only by the model.
    for (int i = 0; i < 200; i++) begin
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      req8      = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      req4      = 4'($urandom);
      req16     = 16'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prio_encoder_hs
